// File: rtl/cell_stream_reader_if.sv
// Cell-memory port and particle-stream bundle between one cell memory, its reader and the force pipeline.
// master = reader side, slave = memory/consumer side.
interface cell_stream_reader_if #(
   parameter int DATA_WIDTH = 96,
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] mem_address;
   logic                  mem_rden;
   logic                  mem_wren;
   logic [DATA_WIDTH-1:0] mem_q;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ADDR_WIDTH-1:0] out_index;
   logic                  out_last;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output mem_address, mem_rden, mem_wren,
      input  mem_q,
      output out_data, out_index, out_last, out_valid,
      input  out_ready
   );

   modport slave (
      input  mem_address, mem_rden, mem_wren,
      output mem_q,
      input  out_data, out_index, out_last, out_valid,
      output out_ready
   );
endinterface

// File: rtl/cell_stream_reader.sv
// Drains one position-cell memory (count at addr 0, particles at 1..N) into a valid/ready stream,
// hiding the 2-cycle RAM latency behind a credit-limited prefetch FIFO.
module cell_stream_reader #(
   parameter int DATA_WIDTH   = 96,
   parameter int ADDR_WIDTH   = 8,
   parameter int PARTICLE_NUM = 220,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] cell_count,
   cell_stream_reader_if.master  bus
);
   localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
   localparam int OCC_WIDTH = $clog2(FIFO_DEPTH + 1);
   localparam int CRD_WIDTH = OCC_WIDTH + 2;
   localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

   typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT0, WAIT_CNT1, STREAM} state_t;

   state_t                state_reg, state_next;
   logic                  rden_reg, rden_next;
   logic [ADDR_WIDTH-1:0] address_reg, address_next;
   logic [ADDR_WIDTH-1:0] count_reg, count_next;
   logic                  done_reg, done_next;

   logic [1:0]            tag_valid_reg;
   logic [ADDR_WIDTH-1:0] tag_index_reg [2];

   logic [DATA_WIDTH-1:0] fifo_data  [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_index [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [OCC_WIDTH-1:0]  occ_reg;

   logic                  particle_read, push, pop, fifo_valid, head_last, credit_ok;
   logic [ADDR_WIDTH-1:0] count_clamped;
   logic [CRD_WIDTH-1:0]  committed;

   function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
      return (ptr == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   // The count read in RD_CNT is never tagged; only STREAM reads travel to the FIFO.
   assign particle_read = rden_reg && (state_reg == STREAM);
   assign push          = tag_valid_reg[1];
   assign fifo_valid    = (occ_reg != '0);
   assign pop           = fifo_valid && bus.out_ready;
   assign head_last     = fifo_valid && (fifo_index[rd_ptr_reg] == count_reg);
   assign count_clamped = (bus.mem_q[ADDR_WIDTH-1:0] > MAX_COUNT) ? MAX_COUNT
                                                                  : bus.mem_q[ADDR_WIDTH-1:0];

   // Next cycle's FIFO fill plus every read still in the RAM pipe, so each issued read owns a slot.
   assign committed = CRD_WIDTH'(occ_reg) + CRD_WIDTH'(push) - CRD_WIDTH'(pop)
                    + CRD_WIDTH'(particle_read) + CRD_WIDTH'(tag_valid_reg[0]);
   assign credit_ok = committed < CRD_WIDTH'(FIFO_DEPTH);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         rden_reg    <= 1'b0;
         address_reg <= '0;
         count_reg   <= '0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         rden_reg    <= rden_next;
         address_reg <= address_next;
         count_reg   <= count_next;
         done_reg    <= done_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      rden_next    = 1'b0;
      address_next = address_reg;
      count_next   = count_reg;
      done_next    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next   = RD_CNT;
               rden_next    = 1'b1;
               address_next = '0;
            end
         end
         RD_CNT:    state_next = WAIT_CNT0;
         WAIT_CNT0: state_next = WAIT_CNT1;
         WAIT_CNT1: begin
            count_next = count_clamped;
            if (count_clamped == '0) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end else begin
               state_next   = STREAM;
               rden_next    = 1'b1;
               address_next = ADDR_WIDTH'(1);
            end
         end
         STREAM: begin
            if ((address_reg < count_reg) && credit_ok) begin
               rden_next    = 1'b1;
               address_next = address_reg + 1'b1;
            end
            if (pop && head_last) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) tag_valid_reg <= '0;
      else          tag_valid_reg <= {tag_valid_reg[0], particle_read};
   end

   always_ff @(posedge clock) begin
      tag_index_reg[0] <= address_reg;
      tag_index_reg[1] <= tag_index_reg[0];
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_data[wr_ptr_reg]  <= bus.mem_q;
         fifo_index[wr_ptr_reg] <= tag_index_reg[1];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
      end else begin
         if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         occ_reg <= occ_reg + OCC_WIDTH'(push) - OCC_WIDTH'(pop);
      end
   end

   assign busy            = (state_reg != IDLE);
   assign done            = done_reg;
   assign cell_count      = count_reg;
   assign bus.mem_address = address_reg;
   assign bus.mem_rden    = rden_reg;
   assign bus.mem_wren    = 1'b0;
   assign bus.out_valid   = fifo_valid;
   assign bus.out_data    = fifo_valid ? fifo_data[rd_ptr_reg]  : '0;
   assign bus.out_index   = fifo_valid ? fifo_index[rd_ptr_reg] : '0;
   assign bus.out_last    = head_last;
endmodule
